// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among ALU/MULT/LB/ACU writebacks
// with same-cycle acknowledgements and a one-cycle registered broadcast.
module cdb_arbiter #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 alu_wr_valid,
  input  logic                 mult_wr_valid,
  input  logic                 lb_wr_valid,
  input  logic                 acu_wr_valid,
  input  logic [ROB_IDX_W-1:0] alu_wr_tag,
  input  logic [ROB_IDX_W-1:0] mult_wr_tag,
  input  logic [ROB_IDX_W-1:0] lb_wr_tag,
  input  logic [ROB_IDX_W-1:0] acu_wr_tag,
  input  logic [XLEN-1:0]      alu_wr_value,
  input  logic [XLEN-1:0]      mult_wr_value,
  input  logic [XLEN-1:0]      lb_wr_value,
  input  logic [XLEN-1:0]      acu_wr_value,
  output logic                 alu_wr_written,
  output logic                 mult_wr_written,
  output logic                 lb_wr_written,
  output logic                 acu_wr_written,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_tag,
  output logic [XLEN-1:0]      cdb_value,
  output logic [1:0]           cdb_src
);

  logic [3:0]           req_p0;
  logic [1:0]           rr_ptr;
  logic                 grant_any_p0;
  logic [1:0]           grant_idx_p0;
  logic [3:0]           grant_vec_p0;
  logic [ROB_IDX_W-1:0] win_tag_p0;
  logic [XLEN-1:0]      win_value_p0;

  logic                 vld_p1;
  logic [ROB_IDX_W-1:0] tag_p1;
  logic [XLEN-1:0]      value_p1;
  logic [1:0]           src_p1;

  // Returns {found, index} of the first requester at or after ptr, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req_p0 = {acu_wr_valid, lb_wr_valid, mult_wr_valid, alu_wr_valid};

  // Stage p0: combinational arbitration, independent of tag/value.
  always_comb begin
    grant_any_p0 = 1'b0;
    grant_idx_p0 = 2'd0;
    grant_vec_p0 = 4'b0000;
    {grant_any_p0, grant_idx_p0} = rr_pick(req_p0, rr_ptr);
    if (!reset || squash) grant_any_p0 = 1'b0;
    if (grant_any_p0) grant_vec_p0 = 4'b0001 << grant_idx_p0;
  end

  assign alu_wr_written  = grant_vec_p0[0];
  assign mult_wr_written = grant_vec_p0[1];
  assign lb_wr_written   = grant_vec_p0[2];
  assign acu_wr_written  = grant_vec_p0[3];

  always_comb begin
    win_tag_p0   = alu_wr_tag;
    win_value_p0 = alu_wr_value;
    case (grant_idx_p0)
      2'd1: begin
        win_tag_p0   = mult_wr_tag;
        win_value_p0 = mult_wr_value;
      end
      2'd2: begin
        win_tag_p0   = lb_wr_tag;
        win_value_p0 = lb_wr_value;
      end
      2'd3: begin
        win_tag_p0   = acu_wr_tag;
        win_value_p0 = acu_wr_value;
      end
      default: begin
        win_tag_p0   = alu_wr_tag;
        win_value_p0 = alu_wr_value;
      end
    endcase
  end

  // Stage p1: broadcast register; payload holds when no grant so the bus stays quiet.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr   <= 2'd0;
      vld_p1   <= 1'b0;
      tag_p1   <= '0;
      value_p1 <= '0;
      src_p1   <= 2'd0;
    end else begin
      vld_p1 <= grant_any_p0;
      if (grant_any_p0) begin
        rr_ptr   <= grant_idx_p0 + 2'd1;
        tag_p1   <= win_tag_p0;
        value_p1 <= win_value_p0;
        src_p1   <= grant_idx_p0;
      end
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_tag   = tag_p1;
  assign cdb_value = value_p1;
  assign cdb_src   = src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter plus fairness sequences.
module tb_cdb_arbiter;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  localparam logic [RW-1:0]   T_ALU  = 5'd10;
  localparam logic [RW-1:0]   T_MULT = 5'd5;
  localparam logic [RW-1:0]   T_LB   = 5'd12;
  localparam logic [RW-1:0]   T_ACU  = 5'd7;
  localparam logic [XLEN-1:0] V_ALU  = 32'h1111_1111;
  localparam logic [XLEN-1:0] V_MULT = 32'hDEAD_BEEF;
  localparam logic [XLEN-1:0] V_LB   = 32'h3333_3333;
  localparam logic [XLEN-1:0] V_ACU  = 32'h4444_4444;

  logic clock = 1'b0;
  logic reset, squash;
  logic alu_wr_valid, mult_wr_valid, lb_wr_valid, acu_wr_valid;
  logic [RW-1:0] alu_wr_tag, mult_wr_tag, lb_wr_tag, acu_wr_tag;
  logic [XLEN-1:0] alu_wr_value, mult_wr_value, lb_wr_value, acu_wr_value;
  logic alu_wr_written, mult_wr_written, lb_wr_written, acu_wr_written;
  logic cdb_valid;
  logic [RW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic [1:0] cdb_src;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.XLEN(XLEN), .ROB_IDX_W(RW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .alu_wr_valid(alu_wr_valid), .mult_wr_valid(mult_wr_valid),
    .lb_wr_valid(lb_wr_valid), .acu_wr_valid(acu_wr_valid),
    .alu_wr_tag(alu_wr_tag), .mult_wr_tag(mult_wr_tag),
    .lb_wr_tag(lb_wr_tag), .acu_wr_tag(acu_wr_tag),
    .alu_wr_value(alu_wr_value), .mult_wr_value(mult_wr_value),
    .lb_wr_value(lb_wr_value), .acu_wr_value(acu_wr_value),
    .alu_wr_written(alu_wr_written), .mult_wr_written(mult_wr_written),
    .lb_wr_written(lb_wr_written), .acu_wr_written(acu_wr_written),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  typedef struct {
    logic       rst;
    logic       sq;
    logic [3:0] v;
    logic [3:0] wr;
    logic       cv;
    logic [1:0] src;
    logic       zero;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic sq, input logic [3:0] v,
                              input logic [3:0] wr, input logic cv, input logic [1:0] src,
                              input logic zero);
    vec_t r;
    r.rst = rst; r.sq = sq; r.v = v; r.wr = wr; r.cv = cv; r.src = src; r.zero = zero;
    return r;
  endfunction

  function automatic logic [RW-1:0] tag_of(input logic [1:0] s);
    case (s)
      2'd0: return T_ALU;
      2'd1: return T_MULT;
      2'd2: return T_LB;
      default: return T_ACU;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] val_of(input logic [1:0] s);
    case (s)
      2'd0: return V_ALU;
      2'd1: return V_MULT;
      2'd2: return V_LB;
      default: return V_ACU;
    endcase
  endfunction

  function automatic logic [3:0] written_vec();
    return {acu_wr_written, lb_wr_written, mult_wr_written, alu_wr_written};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic sq, input logic [3:0] v);
    reset = rst;
    squash = sq;
    {acu_wr_valid, lb_wr_valid, mult_wr_valid, alu_wr_valid} = v;
  endtask

  task automatic run_fair(input string nm, input logic [3:0] v, input int n);
    int starve[4];
    bit seen_zero[4];
    for (int i = 0; i < 4; i++) begin
      starve[i] = 0;
      seen_zero[i] = 1'b0;
    end
    @(negedge clock); drive(1'b0, 1'b0, 4'b0000);
    for (int c = 0; c < n; c++) begin
      @(negedge clock); drive(1'b1, 1'b0, v);
      #1;
      chk($sformatf("%s_onehot_c%0d", nm, c), 32'($countones(written_vec())), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (!written_vec()[i]) begin
            starve[i]++;
            seen_zero[i] = 1'b1;
          end else begin
            starve[i] = 0;
          end
          chk($sformatf("%s_starve_s%0d_c%0d", nm, i, c), 32'(starve[i] <= 3), 32'd1);
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (v[i]) chk($sformatf("%s_blocked_once_s%0d", nm, i), 32'(seen_zero[i]), 32'd1);
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'b1111);
    alu_wr_tag = T_ALU;   alu_wr_value = V_ALU;
    mult_wr_tag = T_MULT; mult_wr_value = V_MULT;
    lb_wr_tag = T_LB;     lb_wr_value = V_LB;
    acu_wr_tag = T_ACU;   acu_wr_value = V_ACU;

    //            rst   sq    v        wr       cv    src   zero
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd3, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'b1100, 4'b0000, 1'b0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1100, 4'b0100, 1'b0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b1, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0101, 4'b0001, 1'b0, 2'd3, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b1));

    foreach (tbl[k]) begin
      @(negedge clock);
      drive(tbl[k].rst, tbl[k].sq, tbl[k].v);
      #1;
      chk($sformatf("row%0d_written", k), 32'(written_vec()), 32'(tbl[k].wr));
      chk($sformatf("row%0d_cdb_valid", k), 32'(cdb_valid), 32'(tbl[k].cv));
      chk($sformatf("row%0d_cdb_src", k), 32'(cdb_src), 32'(tbl[k].zero ? 2'd0 : tbl[k].src));
      chk($sformatf("row%0d_cdb_tag", k), 32'(cdb_tag), 32'(tbl[k].zero ? '0 : tag_of(tbl[k].src)));
      chk($sformatf("row%0d_cdb_value", k), cdb_value, tbl[k].zero ? 32'd0 : val_of(tbl[k].src));
    end

    // Producer changes payload right after its grant; broadcast follows each grant.
    @(negedge clock); drive(1'b0, 1'b0, 4'b0000);
    @(negedge clock); drive(1'b1, 1'b0, 4'b0001);
    alu_wr_tag = 5'd3; alu_wr_value = 32'h0000_0A0A;
    #1 chk("payload_grant0", 32'(alu_wr_written), 32'd1);
    @(negedge clock);
    alu_wr_tag = 5'd9; alu_wr_value = 32'h0000_0B0B;
    #1 chk("payload_tag0", 32'(cdb_tag), 32'd3);
    chk("payload_value0", cdb_value, 32'h0000_0A0A);
    chk("payload_grant1", 32'(alu_wr_written), 32'd1);
    @(negedge clock); drive(1'b1, 1'b0, 4'b0000);
    #1 chk("payload_tag1", 32'(cdb_tag), 32'd9);
    chk("payload_value1", cdb_value, 32'h0000_0B0B);
    chk("payload_valid1", 32'(cdb_valid), 32'd1);
    alu_wr_tag = T_ALU; alu_wr_value = V_ALU;

    run_fair("fair_all", 4'b1111, 12);
    run_fair("fair_alu_mult", 4'b0011, 10);
    run_fair("fair_lb_acu_alu", 4'b1101, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
